ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

PS/2 keyboard front end. It receives device-to-host frames on the PS/2 clock/data lines, validates them, and tracks make, break, extended and shift codes. Its outputs are `ascii` and a 2-bit key `state`, which the game core consumes as `kbd_ascii` and `state`. It sits between the board's PS/2 pins and the typing-game top level, on the system 50 MHz clock.

## Interface
- `TIMEOUT`, default 50000: idle clk cycles mid-frame before the partial frame is discarded (1 ms at 50 MHz).
- `clk` — input, 1 bit: system clock. All logic is on its rising edge.
- `clrn` — input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `ps2_clk` — input, 1 bit: raw PS/2 clock pin, asynchronous.
- `ps2_data` — input, 1 bit: raw PS/2 data pin, asynchronous.
- `ascii` — output, 8 bits: ASCII of the current key; 0x00 if the key has no mapping.
- `scan_code` — output, 8 bits: last non-prefix scan byte accepted.
- `state` — output, 2 bits:
  - 00: no key down
  - 01: key newly pressed
  - 10: key held, typematic repeat seen
  - 11: unused
- `frame_err` — output, 1 bit: sticky; set on a start, parity or stop violation, or on timeout. Cleared only by reset.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_data` each pass through 2 flops. A falling edge is detected as prev=1 and now=0 on the synchronized clock.
- **Receiver:** on each falling edge, shift the synchronized data into an 11-bit register (LSB first) and increment a 4-bit bit count 0..10.
- **Frame check at the 11th edge.** The frame is valid when all of these hold:
  - start bit = 0;
  - stop bit = 1;
  - the XOR of the 8 data bits and the parity bit = 1 (odd parity).
- A valid frame emits the byte to the decoder. An invalid frame sets `frame_err` and drops the byte. Either way the bit count returns to 0.
- **Timeout:** the cycle counter resets on every falling edge. If the bit count ≠ 0 and the counter reaches `TIMEOUT`, the bit count returns to 0 and `frame_err` is set. While idle (bit count = 0) the counter does not run.
- **Decoder FSM** (states IDLE, BRK, EXT, EXT_BRK):
  - IDLE:
    - 0xF0 → BRK.
    - 0xE0 → EXT.
    - 0x12 or 0x59 sets the `shift` flag; no other change.
    - Any other byte is a make.
  - BRK, next byte → IDLE:
    - 0x12 or 0x59 clears `shift`.
    - A byte equal to `scan_code` sets `state` to 00. `ascii` and `scan_code` are retained.
    - Any other byte is ignored.
  - EXT: 0xF0 → EXT_BRK; any other byte → IDLE, discarded, no output change.
  - EXT_BRK: next byte → IDLE, discarded.
- **Make handling:**
  - Byte equal to `scan_code` while `state` is 01 or 10 → `state` = 10; `ascii` unchanged.
  - Otherwise → `scan_code` = byte, `ascii` = map(byte, shift), `state` = 01. This covers a new key pressed while another is held.
- **Mapping:**
  - Letters map to 0x61–0x7A, or 0x41–0x5A with shift.
  - Digits map to 0x30–0x39.
  - Space 0x29 → 0x20; Enter 0x5A → 0x0D.
  - Every other code → 0x00, with `state` still updated.
- **Reset values:** `ascii` = 0, `scan_code` = 0, `state` = 00, `frame_err` = 0, FSM = IDLE, `shift` = 0, bit count = 0, timeout counter = 0, sync flops = 1.

## Timing
- The raw PS/2 falling edge is seen by the edge detector 3 clk later (2 sync flops plus the edge register).
- Byte valid: registered in the cycle after the 11th detected edge.
- Decoder outputs update 1 clk after byte valid, so raw 11th edge to `state`/`ascii` change is 5 clk.
- The decoder accepts one byte per clk and never stalls. PS/2 bytes are at least 60 µs apart, so no buffering is needed.
- `state` is level, not a pulse. The consumer is responsible for its own edge detection and hold-off.
- Reset mid-frame aborts the frame immediately. No byte is emitted after release until a full new frame arrives.
- Reset mid-sequence (e.g. after 0xF0) returns the FSM to IDLE; the pending break is lost.

## Structure
- Shared package `ps2_pkg`:
  - decoder state enum (IDLE/BRK/EXT/EXT_BRK);
  - constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_LSHIFT`=8'h12, `PS2_RSHIFT`=8'h59.
- One sub-module `ps2_scan2ascii`: purely combinational, inputs scan[7:0] and shift, output ascii[7:0]. It keeps the lookup separate from the receiver and FSM.

## Test plan
- Frame 0x1C ('a') → `ascii`=0x61, `scan_code`=0x1C, `state`=01 exactly 5 clk after the raw 11th edge. Then F0 1C → `state`=00, `ascii` stays 0x61.
- 12, 1C, F0 1C, F0 12 → `ascii`=0x41 after the 1C; after the final frame, `state`=00 and `shift`=0. A following 1C gives 0x61.
- 1C, 1C, 1C (typematic) → `state` goes 01, then 10, then stays 10. A following 0x32 ('b') → `state`=01, `ascii`=0x62.
- Frame 0x1C with the parity bit inverted → `frame_err`=1; `state`, `ascii` and `scan_code` unchanged. The next good frame 0x1B ('s') → `ascii`=0x73.
- Sequence E0 75, then E0 F0 75 (extended up-arrow) → no output change. Then 0x45 → `ascii`=0x30.
- Stop `ps2_clk` after 5 bits for `TIMEOUT` clk → `frame_err`=1 and bit count 0. A following full 0x1C frame decodes to 0x61. Asserting `clrn`=0 mid-frame → all outputs return to reset values within 1 clk.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam logic [1:0] KEY_UP   = 2'b00;
    localparam logic [1:0] KEY_NEW  = 2'b01;
    localparam logic [1:0] KEY_HELD = 2'b10;

    function automatic logic is_shift(input logic [7:0] code);
        return (code == PS2_LSHIFT) || (code == PS2_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Scan code set 2 to ASCII lookup; letters honour shift, digits do not.
module ps2_scan2ascii (
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        base   = 8'h00;
        letter = 1'b1;
        case (scan)
            8'h1C: base = 8'h61;
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A;
            default: begin
                letter = 1'b0;
                case (scan)
                    8'h45: base = 8'h30;
                    8'h16: base = 8'h31;
                    8'h1E: base = 8'h32;
                    8'h26: base = 8'h33;
                    8'h25: base = 8'h34;
                    8'h2E: base = 8'h35;
                    8'h36: base = 8'h36;
                    8'h3D: base = 8'h37;
                    8'h3E: base = 8'h38;
                    8'h46: base = 8'h39;
                    8'h29: base = 8'h20;
                    8'h5A: base = 8'h0D;
                    default: base = 8'h00;
                endcase
            end
        endcase
        ascii = (letter && shift) ? (base - 8'h20) : base;
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 receiver with frame validation, timeout and make/break decoder.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic [7:0] scan_code,
    output logic [1:0] state,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic             fall_q, data_q;
    logic [9:0]       sr;
    logic [10:0]      frame;
    logic             frame_ok;
    logic [3:0]       bit_cnt;
    logic [TW-1:0]    to_cnt;
    logic             byte_valid;
    logic [7:0]       rx_byte;

    assign frame    = {data_q, sr};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_prev   <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            fall_q     <= 1'b0;
            data_q     <= 1'b1;
            sr         <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_prev   <= clk_s2;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            fall_q     <= clk_prev & ~clk_s2;
            data_q     <= data_s2;
            byte_valid <= 1'b0;
            if (fall_q) begin
                sr     <= frame[10:1];
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= frame[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled device leaves a partial frame; drop it.
                if (to_cnt == TW'(TIMEOUT)) begin
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    dec_state_e fsm_q, fsm_d;
    logic       shift_q, shift_d;
    logic [7:0] ascii_d, scan_d;
    logic [1:0] key_d;
    logic [7:0] map_ascii;

    ps2_scan2ascii u_map (
        .scan  (rx_byte),
        .shift (shift_q),
        .ascii (map_ascii)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fsm_q     <= IDLE;
            shift_q   <= 1'b0;
            ascii     <= '0;
            scan_code <= '0;
            state     <= KEY_UP;
        end else begin
            fsm_q     <= fsm_d;
            shift_q   <= shift_d;
            ascii     <= ascii_d;
            scan_code <= scan_d;
            state     <= key_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        shift_d = shift_q;
        ascii_d = ascii;
        scan_d  = scan_code;
        key_d   = state;
        if (byte_valid) begin
            unique case (fsm_q)
                IDLE: begin
                    if (rx_byte == PS2_BREAK) begin
                        fsm_d = BRK;
                    end else if (rx_byte == PS2_EXT) begin
                        fsm_d = EXT;
                    end else if (is_shift(rx_byte)) begin
                        shift_d = 1'b1;
                    end else if (rx_byte == scan_code && state != KEY_UP) begin
                        key_d = KEY_HELD;
                    end else begin
                        scan_d  = rx_byte;
                        ascii_d = map_ascii;
                        key_d   = KEY_NEW;
                    end
                end
                BRK: begin
                    fsm_d = IDLE;
                    if (is_shift(rx_byte)) begin
                        shift_d = 1'b0;
                    end else if (rx_byte == scan_code) begin
                        key_d = KEY_UP;
                    end
                end
                EXT: begin
                    fsm_d = (rx_byte == PS2_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    fsm_d = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: vector table plus corner sequences.
module tb_ps2_kbd_decoder;

    localparam int TO = 200;
    localparam int NV = 23;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii, scan_code;
    logic [1:0] state;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pre_ascii, post_ascii, pre_scan, post_scan;
    logic [1:0] pre_state, post_state;

    typedef struct {
        logic [7:0] b;
        logic [7:0] ea;
        logic [7:0] es;
        logic [1:0] est;
    } vec_t;

    vec_t tv[NV];

    ps2_kbd_decoder #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .scan_code (scan_code),
        .state     (state),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    initial begin
        #4ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // mask: bit0 flips parity, bit1 clears stop, bit2 sets start
    task automatic send_frame(input logic [7:0] b, input logic [2:0] mask);
        logic [10:0] f;
        f[0]   = mask[2];
        f[8:1] = b;
        f[9]   = ~(^b) ^ mask[0];
        f[10]  = ~mask[1];
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk);
        ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        pre_ascii = ascii;
        pre_scan  = scan_code;
        pre_state = state;
        @(posedge clk);
        #1;
        post_ascii = ascii;
        post_scan  = scan_code;
        post_state = {6'd0, state};
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ea,
                             input logic [7:0] es, input logic [1:0] est,
                             input logic err);
        chk({tag, " ascii"}, ascii, ea);
        chk({tag, " scan"}, scan_code, es);
        chk({tag, " state"}, {6'd0, state}, {6'd0, est});
        chk({tag, " err"}, {7'd0, frame_err}, {7'd0, err});
    endtask

    initial begin
        logic [7:0] pa, ps;
        logic [1:0] pst;
        tv[0]  = '{8'h1C, 8'h61, 8'h1C, 2'b01};
        tv[1]  = '{8'hF0, 8'h61, 8'h1C, 2'b01};
        tv[2]  = '{8'h1C, 8'h61, 8'h1C, 2'b00};
        tv[3]  = '{8'h12, 8'h61, 8'h1C, 2'b00};
        tv[4]  = '{8'h1C, 8'h41, 8'h1C, 2'b01};
        tv[5]  = '{8'hF0, 8'h41, 8'h1C, 2'b01};
        tv[6]  = '{8'h1C, 8'h41, 8'h1C, 2'b00};
        tv[7]  = '{8'hF0, 8'h41, 8'h1C, 2'b00};
        tv[8]  = '{8'h12, 8'h41, 8'h1C, 2'b00};
        tv[9]  = '{8'h1C, 8'h61, 8'h1C, 2'b01};
        tv[10] = '{8'h1C, 8'h61, 8'h1C, 2'b10};
        tv[11] = '{8'h1C, 8'h61, 8'h1C, 2'b10};
        tv[12] = '{8'h32, 8'h62, 8'h32, 2'b01};
        tv[13] = '{8'hE0, 8'h62, 8'h32, 2'b01};
        tv[14] = '{8'h75, 8'h62, 8'h32, 2'b01};
        tv[15] = '{8'hE0, 8'h62, 8'h32, 2'b01};
        tv[16] = '{8'hF0, 8'h62, 8'h32, 2'b01};
        tv[17] = '{8'h75, 8'h62, 8'h32, 2'b01};
        tv[18] = '{8'h45, 8'h30, 8'h45, 2'b01};
        tv[19] = '{8'h29, 8'h20, 8'h29, 2'b01};
        tv[20] = '{8'h5A, 8'h0D, 8'h5A, 2'b01};
        tv[21] = '{8'h76, 8'h00, 8'h76, 2'b01};
        tv[22] = '{8'h1B, 8'h73, 8'h1B, 2'b01};

        do_reset();
        check_out("reset", 8'h00, 8'h00, 2'b00, 1'b0);

        pa = 8'h00;
        ps = 8'h00;
        pst = 2'b00;
        for (int i = 0; i < NV; i++) begin
            send_frame(tv[i].b, 3'b000);
            chk($sformatf("v%0d pre4 ascii", i), pre_ascii, pa);
            chk($sformatf("v%0d pre4 scan", i), pre_scan, ps);
            chk($sformatf("v%0d pre4 state", i), {6'd0, pre_state}, {6'd0, pst});
            chk($sformatf("v%0d clk5 ascii", i), post_ascii, tv[i].ea);
            chk($sformatf("v%0d clk5 scan", i), post_scan, tv[i].es);
            chk($sformatf("v%0d clk5 state", i), {6'd0, post_state}, {6'd0, tv[i].est});
            chk($sformatf("v%0d err", i), {7'd0, frame_err}, 8'd0);
            pa = tv[i].ea;
            ps = tv[i].es;
            pst = tv[i].est;
        end

        send_frame(8'h1C, 3'b010);
        check_out("bad stop", 8'h73, 8'h1B, 2'b01, 1'b1);

        do_reset();
        check_out("reset2", 8'h00, 8'h00, 2'b00, 1'b0);
        send_frame(8'h1C, 3'b100);
        check_out("bad start", 8'h00, 8'h00, 2'b00, 1'b1);

        do_reset();
        send_frame(8'h1C, 3'b001);
        check_out("bad parity", 8'h00, 8'h00, 2'b00, 1'b1);
        send_frame(8'h1B, 3'b000);
        check_out("after parity", 8'h73, 8'h1B, 2'b01, 1'b1);

        do_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0] ? 1'b1 : 1'b0);
        repeat (TO / 2) @(negedge clk);
        chk("pre timeout err", {7'd0, frame_err}, 8'd0);
        repeat (TO / 2 + 20) @(negedge clk);
        check_out("timeout", 8'h00, 8'h00, 2'b00, 1'b1);
        send_frame(8'h1C, 3'b000);
        check_out("post timeout", 8'h61, 8'h1C, 2'b01, 1'b1);

        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check_out("mid reset", 8'h00, 8'h00, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check_out("after release", 8'h00, 8'h00, 2'b00, 1'b0);
        send_frame(8'h1C, 3'b000);
        check_out("post reset", 8'h61, 8'h1C, 2'b01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
